// File: rtl/whirlpool_round_ctrl_if.sv
// Block handshake bundle for the Whirlpool round controller.
// The master side supplies blocks and consumes results; the controller is the slave.
interface whirlpool_round_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/whirlpool_round_ctrl.sv
// Whirlpool compression-function sequencer: load, NROUNDS round commits, feed-forward, result hold.
// Define WHIRLPOOL_CTRL_SPLIT_ROUND_EN to spread each round over two half-round cycles.
module whirlpool_round_ctrl #(
    parameter int NROUNDS = 10,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 abort,
    whirlpool_round_ctrl_if.slave hs,
    output logic                 ld_en,
    output logic                 rnd_en,
    output logic                 stage_sel,
    output logic [3:0]           rc_idx,
    output logic                 ff_en,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FFWD,
        DONE
    } state_t;

    localparam logic [3:0] RC_LAST = 4'(NROUNDS);

    state_t           state_q, state_d;
    logic [3:0]       rc_q, rc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;
    logic             commit;
    logic             ld_c, rnd_c, ff_c, ov_c, ir_c;

`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
    logic stage_q, stage_d;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        cnt_inc = 1'b0;
        commit  = 1'b0;
        ld_c    = 1'b0;
        rnd_c   = 1'b0;
        ff_c    = 1'b0;
        ov_c    = 1'b0;
        // in_ready is gated by rst so it stays low until reset is released.
        ir_c    = (state_q == IDLE) && !rst;
`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
        stage_d = stage_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (ir_c && hs.in_valid) begin
                    ld_c    = 1'b1;
                    rc_d    = 4'd1;
                    state_d = ROUND;
`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
                    stage_d = 1'b0;
`endif
                end
            end

            ROUND: begin
`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
                // First half (shiftcol/sub) only advances the stage; second half commits.
                commit  = stage_q;
                stage_d = ~stage_q;
`else
                commit  = 1'b1;
`endif
                if (commit) begin
                    rnd_c = 1'b1;
                    if (rc_q == RC_LAST) begin
                        rc_d    = '0;
                        state_d = FFWD;
                    end else begin
                        rc_d = rc_q + 4'd1;
                    end
                end
            end

            FFWD: begin
                ff_c    = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                ov_c = 1'b1;
                if (hs.out_ready) begin
                    cnt_inc = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                rc_d    = '0;
            end
        endcase

        // Abort overrides everything: drop the block without any strobe or count.
        if (abort) begin
            state_d = IDLE;
            rc_d    = '0;
            cnt_inc = 1'b0;
            ld_c    = 1'b0;
            rnd_c   = 1'b0;
            ff_c    = 1'b0;
            ov_c    = 1'b0;
`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
            stage_d = 1'b0;
`endif
        end
    end

    assign hs.in_ready  = ir_c;
    assign hs.out_valid = ov_c;
    assign ld_en        = ld_c;
    assign rnd_en       = rnd_c;
    assign ff_en        = ff_c;
    assign rc_idx       = rc_q;
    assign busy         = (state_q != IDLE);
    assign blk_cnt      = cnt_q;

`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
    assign stage_sel = stage_q;
`else
    assign stage_sel = 1'b0;
`endif

    a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({ld_en, rnd_en, ff_en}));

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(hs.in_ready && hs.out_valid));

    a_rc_range: assert property (@(posedge clk) disable iff (rst)
        rc_idx <= RC_LAST);

endmodule

// File: tb/tb_whirlpool_round_ctrl.sv
// Self-checking bench for whirlpool_round_ctrl: vector table, directed corner sequences,
// and randomized traffic compared against a cycle-offset reference model.
module tb_whirlpool_round_ctrl;
    localparam int NR    = 10;
    localparam int CNT_W = 4;
`ifdef WHIRLPOOL_CTRL_SPLIT_ROUND_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int RL = NR * L;

    logic             clk;
    logic             rst;
    logic             abort;
    logic             ld_en, rnd_en, stage_sel, ff_en, busy;
    logic [3:0]       rc_idx;
    logic [CNT_W-1:0] blk_cnt;

    whirlpool_round_ctrl_if hs ();

    whirlpool_round_ctrl #(.NROUNDS(NR), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .hs        (hs.slave),
        .ld_en     (ld_en),
        .rnd_en    (rnd_en),
        .stage_sel (stage_sel),
        .rc_idx    (rc_idx),
        .ff_en     (ff_en),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: position of the current block in cycles since its handshake.
    bit m_busy;
    int m_k;
    int m_cnt;

    // Values sampled in the most recent cycle.
    logic       o_ld, o_rnd, o_ff, o_ov, o_ir, o_busy, o_ss;
    logic [3:0] o_rc;
    logic [CNT_W-1:0] o_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(hs.in_ready), 0);
        check({tag, "_out_valid"}, 32'(hs.out_valid), 0);
        check({tag, "_strobes"}, 32'({ld_en, rnd_en, ff_en}), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rc_idx"}, 32'(rc_idx), 0);
        check({tag, "_stage_sel"}, 32'(stage_sel), 0);
        check({tag, "_blk_cnt"}, 32'(blk_cnt), 0);
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic cycle(input logic iv, input logic ordy, input logic ab);
        logic e_ir, e_ld, e_rnd, e_ff, e_ov, e_busy, e_ss;
        logic [3:0] e_rc;
        hs.in_valid  = iv;
        hs.out_ready = ordy;
        abort        = ab;
        @(negedge clk);
        {e_ir, e_ld, e_rnd, e_ff, e_ov, e_busy, e_ss} = '0;
        e_rc = '0;
        if (!m_busy) begin
            e_ir = 1'b1;
            e_ld = iv && !ab;
        end else begin
            e_busy = 1'b1;
            if (m_k <= RL) begin
                e_rc  = 4'((m_k - 1) / L + 1);
                e_ss  = (L == 2) && (((m_k - 1) % 2) == 1);
                e_rnd = (((m_k - 1) % L) == L - 1) && !ab;
            end else if (m_k == RL + 1) begin
                e_ff = !ab;
            end else begin
                e_ov = !ab;
            end
        end
        o_ld = ld_en; o_rnd = rnd_en; o_ff = ff_en; o_ov = hs.out_valid;
        o_ir = hs.in_ready; o_busy = busy; o_ss = stage_sel; o_rc = rc_idx; o_cnt = blk_cnt;
        check("in_ready", 32'(o_ir), 32'(e_ir));
        check("ld_en", 32'(o_ld), 32'(e_ld));
        check("rnd_en", 32'(o_rnd), 32'(e_rnd));
        check("ff_en", 32'(o_ff), 32'(e_ff));
        check("out_valid", 32'(o_ov), 32'(e_ov));
        check("busy", 32'(o_busy), 32'(e_busy));
        check("rc_idx", 32'(o_rc), 32'(e_rc));
        check("stage_sel", 32'(o_ss), 32'(e_ss));
        check("blk_cnt", 32'(o_cnt), 32'(m_cnt));
        if (ab) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (iv) begin
                m_busy = 1'b1;
                m_k    = 1;
            end
        end else if (m_k >= RL + 2) begin
            if (ordy) begin
                m_busy = 1'b0;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
        end else begin
            m_k++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv, ordy, ab;
        logic       e_ir, e_ld, e_rnd, e_busy;
        logic [3:0] e_rc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int t_ld, t_ff, t_ov, n_rnd, n_ov, n_ld, cnt0, last_ld, blocks;
        bit saw_wrap, seen;
        logic [CNT_W-1:0] prev_cnt;
        logic one_cyc_round;
        one_cyc_round = (L == 1);

        //             iv  ordy ab   ir  ld  rnd            busy rc
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,          1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,          1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, one_cyc_round, 1'b1, 4'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,          1'b1, one_cyc_round ? 4'd2 : 4'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,          1'b0, 4'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,          1'b0, 4'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, one_cyc_round, 1'b1, 4'd1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,          1'b1, one_cyc_round ? 4'd2 : 4'd1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,          1'b0, 4'd0};

        rst = 1'b1; abort = 1'b0; hs.in_valid = 1'b0; hs.out_ready = 1'b0;
        m_busy = 1'b0; m_k = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        hs.in_valid = 1'b1;
        #1;
        check_reset_outputs("reset");
        check("reset_ld_gated", 32'(ld_en), 0);
        rst = 1'b0;

        // Vector table: abort in IDLE, abort early in ROUND, in_valid ignored while busy.
        foreach (tbl[i]) begin
            cycle(tbl[i].iv, tbl[i].ordy, tbl[i].ab);
            check($sformatf("tbl%0d_in_ready", i), 32'(o_ir), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_ld_en", i), 32'(o_ld), 32'(tbl[i].e_ld));
            check($sformatf("tbl%0d_rnd_en", i), 32'(o_rnd), 32'(tbl[i].e_rnd));
            check($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_rc_idx", i), 32'(o_rc), 32'(tbl[i].e_rc));
        end

        // Full block latency with immediate acceptance.
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        cnt0 = int'(blk_cnt);
        cycle(1'b1, 1'b1, 1'b0);
        check("lat_handshake", 32'(o_ld), 1);
        t_ld = cyc - 1; t_ff = -1; t_ov = -1; n_rnd = 0;
        for (int i = 0; i < 4 * RL + 10 && t_ov < 0; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (o_rnd) n_rnd++;
            if (o_ff) t_ff = cyc - 1;
            if (o_ov) t_ov = cyc - 1;
        end
        check("lat_rnd_count", 32'(n_rnd), 32'(NR));
        check("lat_ff_cycle", 32'(t_ff - t_ld), 32'(RL + 1));
        check("lat_ov_cycle", 32'(t_ov - t_ld), 32'(RL + 2));
        cycle(1'b0, 1'b1, 1'b0);
        check("lat_idle_after", 32'(o_busy), 0);
        check("lat_cnt_inc", 32'(o_cnt), 32'((cnt0 + 1) % 16));

        // Backpressure in DONE: out_valid held 5 cycles, in_valid ignored, one count.
        cnt0 = int'(blk_cnt);
        cycle(1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4 * RL + 10 && !seen; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            seen = o_ov;
        end
        check("bp_reached_done", 32'(seen), 1);
        n_ov = 1; n_ld = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            n_ov += int'(o_ov); n_ld += int'(o_ld);
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_ov += int'(o_ov); n_ld += int'(o_ld);
        check("bp_ov_cycles", 32'(n_ov), 5);
        check("bp_no_ld", 32'(n_ld), 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("bp_cnt_once", 32'(o_cnt), 32'((cnt0 + 1) % 16));

        // Abort at round 3, then a clean block.
        cnt0 = int'(blk_cnt);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4 * RL && rc_idx != 4'd3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("abort_at_rc3", 32'(rc_idx), 3);
        cycle(1'b0, 1'b0, 1'b1);
        check("abort_no_rnd", 32'(o_rnd), 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("abort_idle", 32'(o_ir), 1);
        check("abort_rc0", 32'(o_rc), 0);
        check("abort_cnt_same", 32'(o_cnt), 32'(cnt0));
        cycle(1'b1, 1'b1, 1'b0);
        n_ov = 0;
        for (int i = 0; i < RL + 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            n_ov += int'(o_ov);
        end
        check("abort_next_block_done", 32'(n_ov), 1);

        // Asynchronous reset at round 7.
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4 * RL && rc_idx != 4'd7; i++) cycle(1'b0, 1'b0, 1'b0);
        check("rst_at_rc7", 32'(rc_idx), 7);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        m_busy = 1'b0; m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("rst_release_ready", 32'(o_ir), 1);
        n_ov = 0;
        for (int i = 0; i < RL + 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            n_ov += int'(o_ov) + int'(o_ff);
        end
        check("rst_block_discarded", 32'(n_ov), 0);

        // 17 back-to-back blocks: counter wrap and minimum block period.
        saw_wrap = 1'b0; last_ld = -1; blocks = 0; prev_cnt = blk_cnt;
        for (int i = 0; i < 20 * (RL + 3) && blocks < 17; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (o_ld) begin
                if (last_ld >= 0) check("period", 32'(cyc - 1 - last_ld), 32'(RL + 3));
                last_ld = cyc - 1;
            end
            if (o_ov) blocks++;
            if (prev_cnt == 4'hF && o_cnt == 4'h0) saw_wrap = 1'b1;
            prev_cnt = o_cnt;
        end
        cycle(1'b0, 1'b1, 1'b0);
        check("wrap_blocks_done", 32'(blocks), 17);
        check("wrap_seen", 32'(saw_wrap || (o_cnt == 4'h1 && prev_cnt == 4'h0)), 1);
        check("wrap_final_cnt", 32'(o_cnt), 32'(17 % 16));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/whirlpool_round_ctrl.md
WHIRLPOOL_ROUND_CTRL -- requirements
Module: whirlpool_round_ctrl

Interface
REQ-001 The block SHALL have parameter NROUNDS, default 10: the number of Whirlpool rounds per block, legal range 1..15.
REQ-002 The block SHALL have parameter CNT_W, default 16: the width of the completed-block counter.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port abort  input  1  is a synchronous abort of the block in progress.
REQ-006 Port in_valid  input  1  indicates that the message block and chaining value are present at the datapath inputs.
REQ-007 Port in_ready  output  1  indicates that the controller can accept a block.
REQ-008 Port out_valid  output  1  indicates that the updated chaining value is valid at the datapath output.
REQ-009 Port out_ready  input  1  indicates that the consumer accepts the result.
REQ-010 Port ld_en  output  1  is the datapath load strobe: K0=H, S0=m^H, with m and H saved for feed-forward.
REQ-011 Port rnd_en  output  1  is the round-commit strobe: the key and state registers capture the shiftcol/sub/mixrow/addkey result.
REQ-012 Port stage_sel  output  1  is the round half-select for the split datapath; it is 0 when split mode is not compiled.
REQ-013 Port rc_idx  output  4  is the round-constant index, 1..NROUNDS, and 0 when not in a round.
REQ-014 Port ff_en  output  1  is the Miyaguchi-Preneel feed-forward strobe: H'=S^m^H.
REQ-015 Port busy  output  1  is high in any state other than IDLE.
REQ-016 Port blk_cnt  output  CNT_W  is the count of completed blocks.

Function
REQ-017 The FSM SHALL have the states IDLE, ROUND, FFWD and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, ld_en=1 in that same cycle, rc_idx is loaded to 1, and the next state is ROUND.
REQ-019 ROUND: on each round step, rnd_en=1 and rc_idx=current round; if rc_idx<NROUNDS, rc_idx increments; if rc_idx==NROUNDS, the next state is FFWD.
REQ-020 FFWD: ff_en=1 for exactly one cycle, then DONE.
REQ-021 DONE: out_valid=1 and held stable until out_ready; on out_valid&out_ready, blk_cnt increments and the next state is IDLE.
REQ-022 blk_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-023 in_ready SHALL be 0 in ROUND, FFWD and DONE; in_valid in those states SHALL be ignored, and no ld_en is issued.
REQ-024 Latency without split mode: handshake at cycle t -> rnd_en in cycles t+1..t+NROUNDS -> ff_en at t+NROUNDS+1 -> out_valid from t+NROUNDS+2.
REQ-025 abort SHALL have priority over every other condition: the next state is IDLE, rc_idx=0, and no strobe is issued in the abort cycle, except that ld_en in IDLE is suppressed.
REQ-026 abort does not change blk_cnt.
REQ-027 ld_en, rnd_en and ff_en SHALL be mutually exclusive in every cycle.
REQ-028 out_valid and in_ready SHALL never be high together.
REQ-029 NROUNDS=1 SHALL give exactly one ROUND cycle with rc_idx=1.

Reset
REQ-030 While rst=1, the outputs SHALL be:
- state=IDLE, rc_idx=0, stage_sel=0, blk_cnt=0;
- ld_en=rnd_en=ff_en=out_valid=0;
- busy=0, in_ready=0.
REQ-031 in_ready SHALL rise in the first cycle after rst is deasserted.
REQ-032 rst asserted mid-block SHALL discard the block, and no ff_en or out_valid is produced for it.

Configuration
REQ-033 The macro WHIRLPOOL_CTRL_SPLIT_ROUND_EN selects the split-round mode.
- When it is defined, each round takes 2 cycles: stage_sel=0 in the first cycle (shiftcol/sub half, rnd_en=0) and stage_sel=1 in the second cycle (mixrow/addkey half, rnd_en=1); rc_idx is held across both cycles; latency becomes out_valid from t+2*NROUNDS+2.
- When it is undefined, stage_sel is tied 0 and the timing of REQ-024 applies.
REQ-034 With the macro defined, an abort during stage_sel=1 SHALL suppress that cycle's rnd_en.

Verification
REQ-035 Scenario: NROUNDS=10, no macro; in_valid at cycle 5, out_ready=1 -> ld_en@5; rnd_en@6..15 with rc_idx 1..10; ff_en@16; out_valid@17; IDLE@18; blk_cnt=1.
REQ-036 Scenario: out_ready=0 for 4 cycles in DONE -> out_valid held for 5 cycles; in_valid pulses during that time are ignored (no ld_en); blk_cnt increments once.
REQ-037 Scenario: abort at the 3rd round (rc_idx=3) -> IDLE next cycle; rc_idx=0; no ff_en; blk_cnt unchanged; a new block afterwards completes normally.
REQ-038 Scenario: rst pulsed at rc_idx=7 -> all outputs at reset values immediately (asynchronous); in_ready=1 in the first cycle after release.
REQ-039 Scenario: CNT_W=4, 16 back-to-back blocks -> blk_cnt goes 15 -> 0; the minimum block period is NROUNDS+3 cycles.
REQ-040 Scenario: with WHIRLPOOL_CTRL_SPLIT_ROUND_EN defined -> stage_sel alternates 0,1; rnd_en is high only when stage_sel=1; ff_en@t+21 and out_valid@t+22 for NROUNDS=10.
